// File: rtl/dbg_mem_bridge.sv
// dbg_mem_bridge
//   Byte-stream debug bridge. Single-byte commands arrive on an rx
//   valid/ready channel and are turned into single-lane accesses on a simple
//   memory bus. Read data and status bytes go back on a tx valid/ready channel.
//
//   Commands (accepted only while idle):
//     "i"            return status {VER, 0, busy, OVR, BERR}
//     "a" + AW/8 B   load the address, most significant byte first
//     "w" + D        write one byte
//     "r"            read one byte
//     "n" + C        read C+1 bytes
//     "W" + C + D..  write C+1 bytes
//   Any other byte in idle is discarded.
//
// Ports
//   clk        in   clock, rising edge
//   nreset     in   asynchronous active-low reset
//   rx_valid   in   command/data byte present
//   rx_data    in   [7:0] command/data byte
//   rx_ready   out  byte accepted when rx_valid && rx_ready
//   tx_valid   out  response byte present
//   tx_data    out  [7:0] response byte
//   tx_ready   in   response byte taken when tx_valid && tx_ready
//   mem_addr   out  [AW-1:0] byte address
//   mem_rd     out  read request
//   mem_we     out  [BW-1:0] one-hot byte-lane write enable
//   mem_wdata  out  [8*BW-1:0] write byte replicated on every lane
//   mem_rdata  in   [8*BW-1:0] read data, valid with mem_ack
//   mem_ack    in   access complete
//   mem_cs     out  mem_rd | (|mem_we)
module dbg_mem_bridge #(
  parameter int          AW  = 16,
  parameter int          BW  = 2,
  parameter int          TMO = 255,
  parameter logic [3:0]  VER = 4'h2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  output logic [BW-1:0]   mem_we,
  output logic [8*BW-1:0] mem_wdata,
  input  logic [8*BW-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            mem_cs
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CNT   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_BUS   = 3'd4;
  localparam logic [2:0] S_TX    = 3'd5;

  localparam int          LW        = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [1:0]  ABYTES_M1 = 2'(AW / 8 - 1);
  localparam logic [15:0] TMO_M1    = 16'(TMO - 1);

  localparam logic [7:0] C_STAT  = 8'h69;  // "i"
  localparam logic [7:0] C_ADDR  = 8'h61;  // "a"
  localparam logic [7:0] C_WR    = 8'h77;  // "w"
  localparam logic [7:0] C_RD    = 8'h72;  // "r"
  localparam logic [7:0] C_RDN   = 8'h6E;  // "n"
  localparam logic [7:0] C_WRN   = 8'h57;  // "W"

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    abyte_q, abyte_d;     // address bytes still expected, minus one
  logic [7:0]    cnt_q, cnt_d;         // transfers remaining after the current one
  logic          wr_burst_q, wr_burst_d;
  logic [BW-1:0] we_q, we_d;
  logic          rd_q, rd_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          stat_q, stat_d;       // byte in TX is a status byte
  logic [15:0]   tmo_q, tmo_d;
  logic          ovr_q, ovr_d;
  logic          berr_q, berr_d;

  logic          rx_fire, tx_fire, cs, tmo_hit, done, berr_set, ovr_set, busy;
  logic [LW-1:0] lane;
  logic [BW-1:0] we_onehot;
  logic [7:0]    rd_byte;
  logic [AW-1:0] addr_shift;
  logic [7:0]    rd_lane [BW];

  // Lane selection from the low address bits; a one-lane bus always uses lane 0.
  generate
    if (BW > 1) begin : g_lane_multi
      assign lane = addr_q[LW-1:0];
    end else begin : g_lane_single
      assign lane = '0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_rd_lane
      assign rd_lane[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Address bytes arrive MSB first, so each new byte shifts in at the bottom.
  generate
    if (AW > 8) begin : g_addr_wide
      assign addr_shift = {addr_q[AW-9:0], rx_data};
    end else begin : g_addr_byte
      assign addr_shift = rx_data;
    end
  endgenerate

  assign rx_ready  = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                     (state_q == S_CNT)  || (state_q == S_WDATA);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid_q && tx_ready;
  assign cs        = rd_q | (|we_q);
  assign tmo_hit   = cs && (tmo_q == TMO_M1);
  // A real ack in the timeout cycle wins over the timeout.
  assign done      = cs && (mem_ack || tmo_hit);
  assign berr_set  = tmo_hit && !mem_ack;
  assign ovr_set   = rx_valid && !rx_ready;
  assign rd_byte   = berr_set ? 8'hFF : rd_lane[lane];
  assign we_onehot = BW'(1) << lane;
  // Status can only be requested from idle, so this reads as 0 there.
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    abyte_d    = abyte_q;
    cnt_d      = cnt_q;
    wr_burst_d = wr_burst_q;
    we_d       = we_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    stat_d     = stat_q;
    tmo_d      = cs ? (done ? 16'd0 : tmo_q + 16'd1) : 16'd0;
    ovr_d      = ovr_q;
    berr_d     = berr_q;

    // Clearing on the status handshake comes first so a same-cycle set wins.
    if (tx_fire && stat_q) begin
      ovr_d  = 1'b0;
      berr_d = 1'b0;
    end
    if (ovr_set)  ovr_d  = 1'b1;
    if (berr_set) berr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            C_STAT: begin
              tx_data_d  = {VER, 1'b0, busy, ovr_q, berr_q};
              tx_valid_d = 1'b1;
              stat_d     = 1'b1;
              state_d    = S_TX;
            end
            C_ADDR: begin
              abyte_d = ABYTES_M1;
              state_d = S_ADDR;
            end
            C_WR: begin
              cnt_d      = 8'd0;
              wr_burst_d = 1'b1;
              state_d    = S_WDATA;
            end
            C_RD: begin
              cnt_d   = 8'd0;
              rd_d    = 1'b1;
              state_d = S_BUS;
            end
            C_RDN: begin
              wr_burst_d = 1'b0;
              state_d    = S_CNT;
            end
            C_WRN: begin
              wr_burst_d = 1'b1;
              state_d    = S_CNT;
            end
            default: ;
          endcase
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d  = addr_shift;
          abyte_d = abyte_q - 2'd1;
          if (abyte_q == 2'd0) state_d = S_IDLE;
        end
      end
      S_CNT: begin
        if (rx_fire) begin
          cnt_d = rx_data;
          if (wr_burst_q) begin
            state_d = S_WDATA;
          end else begin
            rd_d    = 1'b1;
            state_d = S_BUS;
          end
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          wdata_d = rx_data;
          we_d    = we_onehot;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (done) begin
          addr_d = addr_q + AW'(1);
          rd_d   = 1'b0;
          we_d   = '0;
          if (rd_q) begin
            tx_data_d  = rd_byte;
            tx_valid_d = 1'b1;
            stat_d     = 1'b0;
            state_d    = S_TX;
          end else if (cnt_q != 8'd0) begin
            cnt_d   = cnt_q - 8'd1;
            state_d = S_WDATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TX: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (!stat_q && (cnt_q != 8'd0)) begin
            cnt_d   = cnt_q - 8'd1;
            rd_d    = 1'b1;
            state_d = S_BUS;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      abyte_q    <= 2'd0;
      cnt_q      <= 8'd0;
      wr_burst_q <= 1'b0;
      we_q       <= '0;
      rd_q       <= 1'b0;
      wdata_q    <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      stat_q     <= 1'b0;
      tmo_q      <= 16'd0;
      ovr_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      abyte_q    <= abyte_d;
      cnt_q      <= cnt_d;
      wr_burst_q <= wr_burst_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      stat_q     <= stat_d;
      tmo_q      <= tmo_d;
      ovr_q      <= ovr_d;
      berr_q     <= berr_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_we    = we_q;
  assign mem_wdata = {BW{wdata_q}};
  assign mem_cs    = cs;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Testbench for dbg_mem_bridge: directed scenarios followed by random
// command sequences, checked against a byte-level reference model.
module tb_dbg_mem_bridge;
  localparam int AW  = 16;
  localparam int BW  = 2;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic [BW-1:0]   mem_we;
  logic [8*BW-1:0] mem_wdata;
  logic [8*BW-1:0] mem_rdata;
  logic            mem_ack;
  logic            mem_cs;

  always #5 clk = ~clk;

  dbg_mem_bridge #(.AW(AW), .BW(BW), .TMO(TMO), .VER(4'h2)) dut (
    .clk(clk), .nreset(nreset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_cs(mem_cs)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0]   addr;
    logic            rd;
    logic [BW-1:0]   we;
    logic [8*BW-1:0] wdata;
  } acc_t;

  acc_t       obs_acc[$];
  acc_t       exp_acc[$];
  logic [7:0] obs_tx[$];
  logic [7:0] exp_tx[$];

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a ^ (a >> 8) ^ 32'h3C) & 32'hFF);
  endfunction

  // ---------------- memory slave (environment) ----------------
  logic [7:0] s_mem [int];
  int  fixed_wait = -1;
  bit  no_ack = 1'b0;
  int  last_dur = 0;

  function automatic logic [7:0] s_rd(input int a);
    if (s_mem.exists(a)) return s_mem[a];
    return init_byte(a);
  endfunction

  initial begin : slave
    int   wcnt;
    int   cur_dur;
    bit   in_acc;
    int   ln;
    acc_t a;
    logic [8*BW-1:0] rd;
    wcnt = 0; cur_dur = 0; in_acc = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        mem_ack = 1'b0; in_acc = 1'b0; cur_dur = 0;
      end else if (mem_cs) begin
        cur_dur++;
        if (!in_acc) begin
          in_acc = 1'b1;
          a.addr = mem_addr; a.rd = mem_rd; a.we = mem_we; a.wdata = mem_wdata;
          obs_acc.push_back(a);
          wcnt = no_ack ? 32'h4000_0000 : ((fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3)));
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          ln = int'(mem_addr) % BW;
          rd = {$urandom, $urandom};
          rd[8*ln +: 8] = s_rd(int'(mem_addr));
          mem_rdata = rd;
          for (int k = 0; k < BW; k++)
            if (mem_we[k]) s_mem[int'(mem_addr)] = mem_wdata[8*k +: 8];
          in_acc = 1'b0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = {$urandom, $urandom};
          wcnt--;
        end
      end else begin
        mem_ack = 1'b0; in_acc = 1'b0;
        if (cur_dur > 0) begin last_dur = cur_dur; cur_dur = 0; end
      end
    end
  end

  // ---------------- tx sink ----------------
  initial begin : sink
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = ($urandom_range(0, 3) != 0);
      if (nreset && tx_valid && tx_ready) obs_tx.push_back(tx_data);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]    m_mem [int];
  logic [AW-1:0] m_addr = '0;
  bit            m_ovr = 1'b0;
  bit            m_berr = 1'b0;

  function automatic logic [7:0] m_rd(input int a);
    if (m_mem.exists(a)) return m_mem[a];
    return init_byte(a);
  endfunction

  task automatic model_write(input logic [7:0] d, input bit commit);
    acc_t a;
    a.addr = m_addr; a.rd = 1'b0;
    a.we = BW'(1) << (int'(m_addr) % BW);
    a.wdata = {BW{d}};
    exp_acc.push_back(a);
    if (commit) begin
      m_mem[int'(m_addr)] = d;
      m_addr = m_addr + 1'b1;
    end
  endtask

  task automatic model_read(input bit timeout);
    acc_t a;
    a.addr = m_addr; a.rd = 1'b1; a.we = '0; a.wdata = '0;
    exp_acc.push_back(a);
    exp_tx.push_back(timeout ? 8'hFF : m_rd(int'(m_addr)));
    if (timeout) m_berr = 1'b1;
    m_addr = m_addr + 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 6000) begin @(negedge clk); n++; end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic quiesce();
    int n = 0;
    while (!(rx_ready && !tx_valid && !mem_cs) && n < 6000) begin @(negedge clk); n++; end
    check("quiesce", 32'(rx_ready && !tx_valid && !mem_cs), 32'd1);
  endtask

  task automatic compare(input string name);
    acc_t o, e;
    logic [7:0] ot, et;
    check({name, "_nacc"}, obs_acc.size(), exp_acc.size());
    while (obs_acc.size() > 0 && exp_acc.size() > 0) begin
      o = obs_acc.pop_front(); e = exp_acc.pop_front();
      check({name, "_acc_addr"}, 32'(o.addr), 32'(e.addr));
      check({name, "_acc_rd"}, 32'(o.rd), 32'(e.rd));
      check({name, "_acc_we"}, 32'(o.we), 32'(e.we));
      if (!e.rd) check({name, "_acc_wdata"}, 32'(o.wdata), 32'(e.wdata));
    end
    check({name, "_ntx"}, obs_tx.size(), exp_tx.size());
    while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      ot = obs_tx.pop_front(); et = exp_tx.pop_front();
      check({name, "_tx"}, 32'(ot), 32'(et));
    end
    check({name, "_addr"}, 32'(mem_addr), 32'(m_addr));
    obs_acc.delete(); exp_acc.delete(); obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic cmd_addr(input logic [AW-1:0] a);
    send(8'h61); send(a[15:8]); send(a[7:0]);
    m_addr = a;
    quiesce(); compare("addr");
  endtask

  task automatic cmd_w(input logic [7:0] d);
    send(8'h77); send(d); model_write(d, 1'b1);
    quiesce(); compare("w");
  endtask

  task automatic cmd_r();
    send(8'h72); model_read(no_ack);
    quiesce(); compare("r");
  endtask

  task automatic cmd_n(input logic [7:0] c);
    send(8'h6E); send(c);
    for (int i = 0; i <= int'(c); i++) model_read(1'b0);
    quiesce(); compare("n");
  endtask

  task automatic cmd_bw(input logic [7:0] c);
    logic [7:0] d;
    send(8'h57); send(c);
    for (int i = 0; i <= int'(c); i++) begin
      d = 8'($urandom); send(d); model_write(d, 1'b1);
    end
    quiesce(); compare("W");
  endtask

  task automatic cmd_i();
    send(8'h69);
    exp_tx.push_back({4'h2, 1'b0, 1'b0, m_ovr, m_berr});
    m_ovr = 1'b0; m_berr = 1'b0;
    quiesce(); compare("i");
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data), 32'd0);
    check({name, "_mem_cs"}, 32'(mem_cs), 32'd0);
    check({name, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({name, "_mem_we"}, 32'(mem_we), 32'd0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] d;
    logic [7:0] jb;
    int sel;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    nreset = 1'b1;
    @(negedge clk);

    // Write at 1234h, lane 0.
    cmd_addr(16'h1234);
    cmd_w(8'hAA);

    // Read with three wait cycles.
    s_mem[16'h1235] = 8'h5A; m_mem[16'h1235] = 8'h5A;
    fixed_wait = 3;
    cmd_r();
    fixed_wait = -1;

    // Burst read wrapping past FFFFh.
    cmd_addr(16'hFFFE);
    fixed_wait = 0;
    cmd_n(8'h03);
    fixed_wait = -1;

    // Timeout read, then status twice.
    no_ack = 1'b1;
    cmd_r();
    no_ack = 1'b0;
    check("tmo_cycles", 32'(last_dur), 32'(TMO));
    cmd_i();
    cmd_i();

    // Overrun while the bus is busy.
    fixed_wait = 6;
    send(8'h72);
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    rx_valid = 1'b0;
    m_ovr = 1'b1;
    model_read(1'b0);
    quiesce(); compare("ovr_r");
    fixed_wait = -1;
    cmd_i();

    // Reset during the third transfer of a write burst.
    cmd_addr(16'h4000);
    fixed_wait = 5;
    send(8'h57); send(8'h03);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom); send(d); model_write(d, i < 2);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    nreset = 1'b1;
    m_addr = '0; m_ovr = 1'b0; m_berr = 1'b0;
    fixed_wait = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_cs", 32'(mem_cs), 32'd0);
    end
    compare("midrst");
    cmd_i();

    // Longest burst: 256 reads.
    cmd_addr(16'(($urandom)));
    fixed_wait = 0;
    cmd_n(8'hFF);
    fixed_wait = -1;

    // Random command mix.
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: cmd_addr(($urandom_range(0, 1) == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom));
        1: cmd_w(8'($urandom));
        2: cmd_r();
        3: cmd_n(8'($urandom_range(0, 6)));
        4: cmd_bw(8'($urandom_range(0, 5)));
        5: cmd_i();
        default: begin
          jb = 8'($urandom);
          while (jb == 8'h61 || jb == 8'h69 || jb == 8'h6E || jb == 8'h72 ||
                 jb == 8'h57 || jb == 8'h77) jb = 8'($urandom);
          send(jb);
          quiesce(); compare("junk");
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
